itch5_msg_tx: RTL and testbench

- Serializes whole ITCH 5.0 messages into the 64-bit beat stream that the ITCH decoder (tv_itch5) consumes: data_o/len_o/start_o plus the overlap lane ov_data_o/ov_len_o.
- The overlap lane carries the start of the next message when it shares a beat with the tail of the current one.
- Sits in the test/replay path. It drives the decoder from a message generator, so the stream is identical to what the MoldUDP64 front end produces after stripping headers.
- The 2-byte MoldUDP64 length prefix is implicit: it occupies beat lanes but is never driven.

---
 rtl/itch5_msg_tx_pkg.sv | 36 +++
 rtl/itch5_msg_tx_slice.sv | 16 +
 rtl/itch5_msg_tx.sv | 119 +++++++++++
 tb/tb_itch5_msg_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/itch5_msg_tx_pkg.sv
// itch5_msg_tx_pkg: ITCH 5.0 beat-stream parameters shared by the transmitter, the decoder and benches,
// plus the per-type message length table.
package itch5_msg_tx_pkg;
    localparam int LEN          = 8;
    localparam int AXI_DATA_W   = 64;
    localparam int KEEP_LW      = 4;
    localparam int OV_DATA_W    = 48;
    localparam int OV_KEEP_LW   = 3;
    localparam int MSG_MAX_LEN  = 50;
    localparam int MSG_LEN_W    = 6;
    localparam int MOLD_HDR_LEN = 2;
    localparam int MSG_W        = MSG_MAX_LEN * LEN;

    typedef enum logic {IDLE, SEND} state_t;

    function automatic logic [MSG_LEN_W-1:0] itch_msg_len(input logic [7:0] t);
        case (t)
            "S", "W":           itch_msg_len = 6'd12;
            "R":                itch_msg_len = 6'd39;
            "H":                itch_msg_len = 6'd25;
            "Y", "N":           itch_msg_len = 6'd20;
            "L":                itch_msg_len = 6'd26;
            "V", "J", "U":      itch_msg_len = 6'd35;
            "K":                itch_msg_len = 6'd28;
            "h":                itch_msg_len = 6'd21;
            "A", "C":           itch_msg_len = 6'd36;
            "F", "Q":           itch_msg_len = 6'd40;
            "E":                itch_msg_len = 6'd31;
            "X":                itch_msg_len = 6'd23;
            "D", "B":           itch_msg_len = 6'd19;
            "P":                itch_msg_len = 6'd44;
            "I":                itch_msg_len = 6'd50;
            default:            itch_msg_len = 6'd0;
        endcase
    endfunction
endpackage

// File: rtl/itch5_msg_tx_slice.sv
// itch5_tx_slice: picks the bytes at a byte offset of a message vector and zeroes lanes at and past cnt.
module itch5_tx_slice
    import itch5_msg_tx_pkg::*;
#(
    parameter int W = AXI_DATA_W
) (
    input  logic [MSG_W-1:0]     data,
    input  logic [MSG_LEN_W-1:0] off,
    input  logic [KEEP_LW-1:0]   cnt,
    output logic [W-1:0]         out
);
    logic [W-1:0] mask;

    assign mask = cnt[KEEP_LW-1] ? '1 : ~({W{1'b1}} << {cnt[KEEP_LW-2:0], 3'b000});
    assign out  = W'(data >> {off, 3'b000}) & mask;
endmodule

// File: rtl/itch5_msg_tx.sv
// itch5_msg_tx: serializes whole ITCH 5.0 messages into 64-bit decoder beats, packing the head of the
// next message into the overlap lane when it shares a beat with the tail of the current one.
module itch5_msg_tx
    import itch5_msg_tx_pkg::*;
(
    input  logic                   clk,
    input  logic                   nreset,
`ifdef DEBUG_ID
    input  logic [63:0]            debug_id_i,
    output logic [63:0]            debug_id_o,
`endif
    input  logic                   msg_valid_i,
    output logic                   msg_ready_o,
    input  logic [MSG_LEN_W-1:0]   msg_len_i,
    input  logic [MSG_W-1:0]       msg_data_i,
    output logic                   valid_o,
    output logic                   start_o,
    output logic [KEEP_LW-1:0]     len_o,
    output logic [AXI_DATA_W-1:0]  data_o,
    output logic                   ov_valid_o,
    output logic [OV_KEEP_LW-1:0]  ov_len_o,
    output logic [OV_DATA_W-1:0]   ov_data_o
);
    state_t                 state;
    logic                   nxt_v, idle, go, has_nxt, last, ov, consume;
    logic [MSG_W-1:0]       nxt_data, cur_data, src_data;
    logic [MSG_LEN_W-1:0]   nxt_len, cur_len, off, src_len, src_off, rem;
    logic [OV_KEEP_LW-1:0]  ov_len;
    logic [KEEP_LW-1:0]     cnt;
    logic [AXI_DATA_W-1:0]  beat;
    logic [OV_DATA_W-1:0]   ov_beat;

    // When idle the pending slot is promoted and its first beat emitted on the same edge
    assign msg_ready_o = ~nxt_v;
    assign idle        = state == IDLE;
    assign src_data    = idle ? nxt_data : cur_data;
    assign src_len     = idle ? nxt_len : cur_len;
    assign src_off     = idle ? '0 : off;
    assign rem         = src_len - src_off;
    assign go          = ~idle | nxt_v;
    assign has_nxt     = ~idle & nxt_v;
    assign last        = rem <= MSG_LEN_W'(8);
    assign ov          = has_nxt & (rem <= MSG_LEN_W'(5));
    assign consume     = idle ? nxt_v : last & nxt_v;
    assign ov_len      = ov ? 3'd6 - rem[OV_KEEP_LW-1:0] : '0;
    assign cnt         = last ? rem[KEEP_LW-1:0] : KEEP_LW'(8);

    itch5_tx_slice #(.W(AXI_DATA_W)) data_slice (
        .data(src_data), .off(src_off), .cnt(cnt), .out(beat)
    );

    itch5_tx_slice #(.W(OV_DATA_W)) ov_slice (
        .data(nxt_data), .off('0), .cnt({1'b0, ov_len}), .out(ov_beat)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            nxt_v      <= 1'b0;
            nxt_data   <= '0;
            nxt_len    <= '0;
            cur_data   <= '0;
            cur_len    <= '0;
            off        <= '0;
            valid_o    <= 1'b0;
            start_o    <= 1'b0;
            len_o      <= '0;
            data_o     <= '0;
            ov_valid_o <= 1'b0;
            ov_len_o   <= '0;
            ov_data_o  <= '0;
        end else begin
            valid_o    <= go;
            start_o    <= go && src_off == '0;
            len_o      <= go ? cnt : '0;
            data_o     <= go ? beat : '0;
            ov_valid_o <= ov;
            ov_len_o   <= ov_len;
            ov_data_o  <= ov_beat;
            nxt_v      <= nxt_v ? ~consume : msg_valid_i;
            if (!nxt_v && msg_valid_i) begin
                nxt_data <= msg_data_i;
                nxt_len  <= msg_len_i;
            end
            if (go && !last) begin
                cur_data <= src_data;
                cur_len  <= src_len;
                off      <= src_off + MSG_LEN_W'(8);
                state    <= SEND;
            end else if (has_nxt) begin
                cur_data <= nxt_data;
                cur_len  <= nxt_len;
                off      <= MSG_LEN_W'(ov_len);
                state    <= SEND;
            end else if (go) begin
                state <= IDLE;
            end
        end
    end

`ifdef DEBUG_ID
    logic [63:0] nxt_id, cur_id;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            nxt_id     <= '0;
            cur_id     <= '0;
            debug_id_o <= '0;
        end else begin
            if (!nxt_v && msg_valid_i) nxt_id <= debug_id_i;
            if (consume) cur_id <= nxt_id;
            debug_id_o <= idle ? nxt_id : cur_id;
        end
    end
`endif

    assert property (@(posedge clk) disable iff (!nreset)
        (msg_valid_i && msg_ready_o) |-> (msg_len_i >= MSG_LEN_W'(8) && msg_len_i <= MSG_LEN_W'(MSG_MAX_LEN)));
endmodule

// File: tb/tb_itch5_msg_tx.sv
// tb_itch5_msg_tx: directed vectors for itch5_msg_tx; a negedge monitor records every beat and the
// initial block compares them against hand-computed beats and, for the backpressure case, input bytes.
module tb_itch5_msg_tx;
    import itch5_msg_tx_pkg::*;

    typedef struct packed {
        logic                  start;
        logic [KEEP_LW-1:0]    len;
        logic [AXI_DATA_W-1:0] data;
        logic                  ovv;
        logic [OV_KEEP_LW-1:0] ovl;
        logic [OV_DATA_W-1:0]  ovd;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  nreset = 1'b1;
    logic                  msg_valid_i = 1'b0;
    logic [MSG_LEN_W-1:0]  msg_len_i = '0;
    logic [MSG_W-1:0]      msg_data_i = '0;
    logic                  msg_ready_o, valid_o, start_o, ov_valid_o;
    logic [KEEP_LW-1:0]    len_o;
    logic [AXI_DATA_W-1:0] data_o;
    logic [OV_KEEP_LW-1:0] ov_len_o;
    logic [OV_DATA_W-1:0]  ov_data_o;

    int vectors = 0;
    int miscompares = 0;
    beat_t beats[$];
    logic [7:0] got_b[$];
    logic [7:0] exp_b[$];
    logic [MSG_W-1:0] bp[3];
    logic [MSG_LEN_W-1:0] bl[3];
    logic [MSG_W-1:0] m_g, m_a, m_s, m_22, m_24;
    int nstart, nov;

    always #5 clk = ~clk;

    itch5_msg_tx dut (
        .clk(clk), .nreset(nreset),
        .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
        .msg_len_i(msg_len_i), .msg_data_i(msg_data_i),
        .valid_o(valid_o), .start_o(start_o), .len_o(len_o), .data_o(data_o),
        .ov_valid_o(ov_valid_o), .ov_len_o(ov_len_o), .ov_data_o(ov_data_o)
    );

    always @(negedge clk)
        if (valid_o) beats.push_back('{start_o, len_o, data_o, ov_valid_o, ov_len_o, ov_data_o});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int i, input logic st, input logic [3:0] ln,
                              input logic [63:0] d, input logic ovv, input logic [2:0] ovl,
                              input logic [47:0] ovd);
        beat_t b;
        b = (i < beats.size()) ? beats[i] : '0;
        check($sformatf("%s[%0d] ctl", tag, i), 64'({b.start, b.len, b.ovv, b.ovl}), 64'({st, ln, ovv, ovl}));
        check($sformatf("%s[%0d] data", tag, i), b.data, d);
        check($sformatf("%s[%0d] ov_data", tag, i), 64'(b.ovd), 64'(ovd));
    endtask

    task automatic send(input logic [MSG_W-1:0] d, input logic [MSG_LEN_W-1:0] l);
        int n = 0;
        msg_valid_i = 1'b1;
        msg_data_i  = d;
        msg_len_i   = l;
        while (!msg_ready_o && n < 100) begin
            tick();
            n++;
        end
        check("send timeout", 64'(n < 100), 64'(1));
        tick();
        msg_valid_i = 1'b0;
    endtask

    // byte 0 = b0; byte k = base + inc*((k-1)/grp) for 1 <= k < n
    function automatic logic [MSG_W-1:0] mk(input logic [7:0] b0, input int n, input logic [7:0] base,
                                            input logic [7:0] inc, input int grp);
        logic [MSG_W-1:0] m = '0;
        m[7:0] = b0;
        for (int k = 1; k < n; k++) m[8*k +: 8] = base + inc * 8'((k - 1) / grp);
        return m;
    endfunction

    initial begin
        m_g  = mk(8'h47, 21, 8'hFF, 8'h00, 1);
        m_a  = mk(8'h41, 36, 8'hAA, 8'h11, 8);
        m_s  = mk(8'h53, 12, 8'h01, 8'h01, 1);
        m_22 = mk(8'h31, 22, 8'h20, 8'h01, 1);
        m_24 = mk(8'h61, 24, 8'h40, 8'h01, 1);

        #2 nreset = 1'b0;
        repeat (2) tick();
        check("reset ctl", 64'({valid_o, start_o, ov_valid_o, len_o, ov_len_o, msg_ready_o}), 64'h001);
        nreset = 1'b1;
        tick();

        // 21-byte G then 36-byte A: tail of G shares a beat with A's type byte
        send(m_g, 6'd21);
        send(m_a, itch_msg_len("A"));
        repeat (12) tick();
        check("ga count", 64'(beats.size()), 64'(8));
        check_beat("ga", 0, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FF47, 1'b0, 3'd0, 48'h0);
        check_beat("ga", 1, 1'b0, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 48'h0);
        check_beat("ga", 2, 1'b0, 4'd5, 64'h0000_00FF_FFFF_FFFF, 1'b1, 3'd1, 48'h41);
        check_beat("ga", 3, 1'b0, 4'd8, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 3'd0, 48'h0);
        check_beat("ga", 4, 1'b0, 4'd8, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 3'd0, 48'h0);
        check_beat("ga", 5, 1'b0, 4'd8, 64'hCCCC_CCCC_CCCC_CCCC, 1'b0, 3'd0, 48'h0);
        check_beat("ga", 6, 1'b0, 4'd8, 64'hDDDD_DDDD_DDDD_DDDD, 1'b0, 3'd0, 48'h0);
        check_beat("ga", 7, 1'b0, 4'd3, 64'h0000_0000_00EE_EEEE, 1'b0, 3'd0, 48'h0);
        check("ga idle valid", 64'(valid_o), 64'(0));

        // lone 12-byte message
        beats.delete();
        send(m_s, itch_msg_len("S"));
        check("lone ready full", 64'(msg_ready_o), 64'(0));
        tick();
        check("lone b0 ready/valid/start", 64'({msg_ready_o, valid_o, start_o}), 64'b111);
        tick();
        check("lone b1 ready/valid/start/len", 64'({msg_ready_o, valid_o, start_o, len_o}), 64'({3'b110, 4'd4}));
        tick();
        check("lone drop", 64'({msg_ready_o, valid_o}), 64'b10);
        check("lone count", 64'(beats.size()), 64'(2));
        check_beat("lone", 0, 1'b1, 4'd8, 64'h0706_0504_0302_0153, 1'b0, 3'd0, 48'h0);
        check_beat("lone", 1, 1'b0, 4'd4, 64'h0000_0000_0B0A_0908, 1'b0, 3'd0, 48'h0);

        // rem=6 with a message pending: no overlap, successor starts fresh on the next beat
        beats.delete();
        send(m_22, 6'd22);
        send(m_s, 6'd12);
        repeat (10) tick();
        check("rem6 count", 64'(beats.size()), 64'(5));
        check_beat("rem6", 1, 1'b0, 4'd8, 64'h2E2D_2C2B_2A29_2827, 1'b0, 3'd0, 48'h0);
        check_beat("rem6", 2, 1'b0, 4'd6, 64'h0000_3433_3231_302F, 1'b0, 3'd0, 48'h0);
        check_beat("rem6", 3, 1'b1, 4'd8, 64'h0706_0504_0302_0153, 1'b0, 3'd0, 48'h0);
        check_beat("rem6", 4, 1'b0, 4'd4, 64'h0000_0000_0B0A_0908, 1'b0, 3'd0, 48'h0);

        // rem=8 with a message pending
        beats.delete();
        send(m_24, 6'd24);
        send(m_s, 6'd12);
        repeat (10) tick();
        check("rem8 count", 64'(beats.size()), 64'(5));
        check_beat("rem8", 0, 1'b1, 4'd8, 64'h4645_4443_4241_4061, 1'b0, 3'd0, 48'h0);
        check_beat("rem8", 2, 1'b0, 4'd8, 64'h5655_5453_5251_504F, 1'b0, 3'd0, 48'h0);
        check_beat("rem8", 3, 1'b1, 4'd8, 64'h0706_0504_0302_0153, 1'b0, 3'd0, 48'h0);

        // backpressure: valid held high across three messages, stream rebuilt byte by byte
        beats.delete();
        bp[0] = mk(8'h46, 20, 8'h10, 8'h03, 1); bl[0] = 6'd20;
        bp[1] = mk(8'h45, 13, 8'h80, 8'h01, 1); bl[1] = 6'd13;
        bp[2] = mk(8'h55, 30, 8'hC0, 8'h02, 1); bl[2] = 6'd30;
        for (int i = 0; i < 3; i++) begin
            send(bp[i], bl[i]);
            msg_valid_i = 1'b1;
            check($sformatf("bp ready low %0d", i), 64'(msg_ready_o), 64'(0));
        end
        msg_valid_i = 1'b0;
        repeat (15) tick();
        nstart = 0;
        nov = 0;
        foreach (beats[i]) begin
            for (int k = 0; k < int'(beats[i].len); k++) got_b.push_back(beats[i].data[8*k +: 8]);
            for (int k = 0; k < int'(beats[i].ovl); k++) got_b.push_back(beats[i].ovd[8*k +: 8]);
            nstart += int'(beats[i].start);
            nov += int'(beats[i].ovv);
        end
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < int'(bl[i]); k++) exp_b.push_back(bp[i][8*k +: 8]);
        check("bp byte count", 64'(got_b.size()), 64'(63));
        check("bp starts/overlaps", 64'({nstart[7:0], nov[7:0]}), 64'h0102);
        for (int i = 0; i < exp_b.size(); i++)
            check($sformatf("bp byte %0d", i), 64'((i < got_b.size()) ? {1'b0, got_b[i]} : 9'h100),
                  64'({1'b0, exp_b[i]}));

        // reset during the second beat of a 36-byte message with a successor pending
        send(m_a, 6'd36);
        msg_data_i  = m_s;
        msg_len_i   = 6'd12;
        msg_valid_i = 1'b1;
        tick();
        tick();
        check("rst pre ready/valid", 64'({msg_ready_o, valid_o}), 64'b01);
        msg_valid_i = 1'b0;
        #2 nreset = 1'b0;
        #1;
        check("rst async ctl", 64'({valid_o, ov_valid_o, start_o, len_o, msg_ready_o}), 64'h001);
        tick();
        nreset = 1'b1;
        repeat (3) tick();
        check("rst pending dropped", 64'(valid_o), 64'(0));
        beats.delete();
        send(m_s, 6'd12);
        repeat (6) tick();
        check("rst new count", 64'(beats.size()), 64'(2));
        check_beat("rst new", 0, 1'b1, 4'd8, 64'h0706_0504_0302_0153, 1'b0, 3'd0, 48'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
